atm_session_ctrl: RTL and testbench
===================================

Name: atm_session_ctrl

Overview:
Parametrised multi-account ATM session controller. Holds an on-chip balance/PIN store. Runs a card→PIN→menu session with multiple operations per session, per-account PIN-retry lockout, a per-session withdrawal limit, an inactivity timeout and a valid/response handshake. Sits between the front-panel input logic and the display/dispenser logic.

Parameters:
NUM_ACC, 16, number of accounts; AW = clog2(NUM_ACC), minimum 1
BAL_W, 32, balance and amount width
PIN_W, 16, PIN width
INIT_BAL, 1000, reset balance of every account
DEFAULT_PIN, 1234, reset PIN of every account
MAX_TRIES, 3, consecutive wrong PINs before the account locks
WD_LIMIT, 500, maximum total withdrawn per session
TIMEOUT_CYC, 16, idle cycles allowed in WAIT_PIN/MENU before the session aborts

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
card_valid  in  1  card inserted; acc_num is valid
acc_num  in  4  account number (AW bits when NUM_ACC≠16)
pin_valid  in  1  pin is valid
pin  in  PIN_W  entered PIN
op_valid  in  1  op is valid
op  in  3  0 BALANCE, 1 WITHDRAW, 2 DEPOSIT, 3 CHANGE_PIN, 4 EXIT
amount  in  BAL_W  withdraw/deposit amount
new_pin  in  PIN_W  CHANGE_PIN value
eject  in  1  abort the session
state  out  3  0 IDLE, 1 WAIT_PIN, 2 MENU, 3 EXEC
resp_valid  out  1  one-cycle response pulse
success  out  1  qualified by resp_valid
err_code  out  3  0 OK, 1 NO_ACC, 2 LOCKED, 3 BAD_PIN, 4 FUNDS, 5 LIMIT, 6 OVF, 7 TIMEOUT
balance  out  BAL_W  balance of the session account; updated with resp_valid
locked  out  1  the session account is locked

Behaviour:
- Reset (async): state=IDLE; resp_valid=0, success=0, err_code=0, balance=0, locked=0; all balances=INIT_BAL; all PINs=DEFAULT_PIN; all try counters and lock bits cleared; session withdrawn total=0. A reset mid-session discards the session.
- All outputs are registered. A response is produced in the cycle after the input is sampled (latency 1). resp_valid is high for exactly one cycle.
- IDLE, card_valid=1:
  - acc_num≥NUM_ACC → resp NO_ACC, stay in IDLE.
  - account locked → resp LOCKED, locked=1, stay in IDLE.
  - otherwise → latch the account, go to WAIT_PIN, clear the timeout counter and the withdrawn total. No response.
- WAIT_PIN, pin_valid=1:
  - PIN matches → clear tries, go to MENU, resp OK.
  - PIN does not match → tries+1, resp BAD_PIN, stay in WAIT_PIN.
  - If tries reaches MAX_TRIES → set the lock bit, resp LOCKED (not BAD_PIN), locked=1, go to IDLE.
- MENU, op_valid=1 → go to EXEC; the operation commits there and the FSM returns to MENU on the next cycle with resp_valid. Inputs arriving during EXEC are ignored.
  - BALANCE: success.
  - WITHDRAW: checked in order. amount>balance → FUNDS. withdrawn+amount>WD_LIMIT → LIMIT. Otherwise subtract and add to withdrawn. amount=0 succeeds with no change.
  - DEPOSIT: if the sum overflows BAL_W bits (carry out) → OVF and no change; else add.
  - CHANGE_PIN: new_pin=0 → BAD_PIN; else store it.
  - EXIT: resp OK, go to IDLE (no EXEC pass).
  - Undefined op codes 5–7: ignored, remain in MENU.
  - Failed operations change no state.
- Timeout: in WAIT_PIN or MENU, the counter increments each cycle with no valid input. When it reaches TIMEOUT_CYC → resp TIMEOUT, go to IDLE. Any accepted input clears the counter.
- eject in WAIT_PIN/MENU → IDLE, no response. eject has priority over pin_valid/op_valid in the same cycle. eject in EXEC takes effect after the commit.
- Overlapping valids are decoded only in the state that expects them.
- The lock bit clears only on reset.

Decomposition:
- Package atm_pkg: state encoding, op codes, err codes.
- Sub-module atm_account_store: balance/PIN/tries/lock arrays with one read port and one write port, written synchronously.
- The FSM, timeout counter and limit checks stay in the top level.

Test Plan:
- acc 3, pin 1234, BALANCE → resp OK, balance=1000. EXIT → state IDLE.
- WITHDRAW 300 then 250 → first: success, balance=700. Second: LIMIT, balance stays 700. Next session WITHDRAW 250 → balance=450.
- WITHDRAW 1200 → FUNDS. DEPOSIT 2^32-500 on balance 1000 → OVF; balance unchanged.
- Three wrong PINs on acc 5 → BAD_PIN, BAD_PIN, LOCKED. Reinsert acc 5 → LOCKED with no PIN prompt. Async reset → acc 5 usable again.
- CHANGE_PIN 4321 → OK. EXIT, reinsert, pin 1234 → BAD_PIN; pin 4321 → MENU. acc_num 12 with NUM_ACC=10 → NO_ACC.
- Idle TIMEOUT_CYC cycles in MENU → TIMEOUT and IDLE. eject together with op_valid → IDLE, no response. rst low during EXEC → all outputs at reset values.

Source files
------------

// File: rtl/atm_pkg.sv
// atm_pkg: shared encodings for the ATM session controller.
package atm_pkg;
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_WAIT_PIN = 3'd1;
    localparam logic [2:0] ST_MENU     = 3'd2;
    localparam logic [2:0] ST_EXEC     = 3'd3;

    localparam logic [2:0] OP_BALANCE    = 3'd0;
    localparam logic [2:0] OP_WITHDRAW   = 3'd1;
    localparam logic [2:0] OP_DEPOSIT    = 3'd2;
    localparam logic [2:0] OP_CHANGE_PIN = 3'd3;
    localparam logic [2:0] OP_EXIT       = 3'd4;

    localparam logic [2:0] ERR_OK      = 3'd0;
    localparam logic [2:0] ERR_NO_ACC  = 3'd1;
    localparam logic [2:0] ERR_LOCKED  = 3'd2;
    localparam logic [2:0] ERR_BAD_PIN = 3'd3;
    localparam logic [2:0] ERR_FUNDS   = 3'd4;
    localparam logic [2:0] ERR_LIMIT   = 3'd5;
    localparam logic [2:0] ERR_OVF     = 3'd6;
    localparam logic [2:0] ERR_TIMEOUT = 3'd7;
endpackage

// File: rtl/atm_account_store.sv
// atm_account_store: per-account balance/PIN/tries/lock arrays.
// One combinational read port, one synchronous full-record write port.
module atm_account_store
    import atm_pkg::*;
#(
    parameter int NUM_ACC     = 16,
    parameter int AW          = 4,
    parameter int BAL_W       = 32,
    parameter int PIN_W       = 16,
    parameter int TW          = 2,
    parameter int INIT_BAL    = 1000,
    parameter int DEFAULT_PIN = 1234
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [AW-1:0]    rd_addr,
    output logic [BAL_W-1:0] rd_bal,
    output logic [PIN_W-1:0] rd_pin,
    output logic [TW-1:0]    rd_tries,
    output logic             rd_lock,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [BAL_W-1:0] wr_bal,
    input  logic [PIN_W-1:0] wr_pin,
    input  logic [TW-1:0]    wr_tries,
    input  logic             wr_lock
);
    logic [BAL_W-1:0] bal_q   [NUM_ACC];
    logic [PIN_W-1:0] pin_q   [NUM_ACC];
    logic [TW-1:0]    tries_q [NUM_ACC];
    logic             lock_q  [NUM_ACC];
    logic             rd_ok;

    // Out-of-range addresses read as an empty, unlocked account.
    assign rd_ok    = 32'(rd_addr) < NUM_ACC;
    assign rd_bal   = rd_ok ? bal_q[rd_addr]   : '0;
    assign rd_pin   = rd_ok ? pin_q[rd_addr]   : '0;
    assign rd_tries = rd_ok ? tries_q[rd_addr] : '0;
    assign rd_lock  = rd_ok ? lock_q[rd_addr]  : 1'b0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_ACC; i++) begin
                bal_q[i]   <= BAL_W'(INIT_BAL);
                pin_q[i]   <= PIN_W'(DEFAULT_PIN);
                tries_q[i] <= '0;
                lock_q[i]  <= 1'b0;
            end
        end else if (wr_en) begin
            bal_q[wr_addr]   <= wr_bal;
            pin_q[wr_addr]   <= wr_pin;
            tries_q[wr_addr] <= wr_tries;
            lock_q[wr_addr]  <= wr_lock;
        end
    end
endmodule

// File: rtl/atm_session_ctrl.sv
// atm_session_ctrl: card -> PIN -> menu session FSM with retry lockout,
// per-session withdrawal limit, inactivity timeout and registered responses.
module atm_session_ctrl
    import atm_pkg::*;
#(
    parameter int NUM_ACC     = 16,
    parameter int BAL_W       = 32,
    parameter int PIN_W       = 16,
    parameter int INIT_BAL    = 1000,
    parameter int DEFAULT_PIN = 1234,
    parameter int MAX_TRIES   = 3,
    parameter int WD_LIMIT    = 500,
    parameter int TIMEOUT_CYC = 16,
    parameter int AW          = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             card_valid,
    input  logic [AW-1:0]    acc_num,
    input  logic             pin_valid,
    input  logic [PIN_W-1:0] pin,
    input  logic             op_valid,
    input  logic [2:0]       op,
    input  logic [BAL_W-1:0] amount,
    input  logic [PIN_W-1:0] new_pin,
    input  logic             eject,
    output logic [2:0]       state,
    output logic             resp_valid,
    output logic             success,
    output logic [2:0]       err_code,
    output logic [BAL_W-1:0] balance,
    output logic             locked
);
    localparam int TW  = $clog2(MAX_TRIES + 1);
    localparam int TCW = $clog2(TIMEOUT_CYC + 1);

    logic [2:0]       state_q, state_d;
    logic [AW-1:0]    acc_q, acc_d;
    logic [TCW-1:0]   tmo_q, tmo_d;
    logic [BAL_W-1:0] wd_q, wd_d;
    logic [2:0]       op_q, op_d;
    logic [BAL_W-1:0] amt_q, amt_d;
    logic [PIN_W-1:0] npin_q, npin_d;
    logic             resp_valid_q, resp_valid_d;
    logic             success_q, success_d;
    logic [2:0]       err_q, err_d;
    logic [BAL_W-1:0] balance_q, balance_d;
    logic             locked_q, locked_d;

    logic [AW-1:0]    rd_addr;
    logic [BAL_W-1:0] rd_bal, wr_bal;
    logic [PIN_W-1:0] rd_pin, wr_pin;
    logic [TW-1:0]    rd_tries, wr_tries, tries_inc;
    logic             rd_lock, wr_lock, wr_en;
    logic             acc_bad, tmo_hit, tries_hit;
    logic [BAL_W:0]   wd_sum, dep_sum;

    atm_account_store #(
        .NUM_ACC(NUM_ACC), .AW(AW), .BAL_W(BAL_W), .PIN_W(PIN_W), .TW(TW),
        .INIT_BAL(INIT_BAL), .DEFAULT_PIN(DEFAULT_PIN)
    ) u_store (
        .clk(clk), .rst(rst),
        .rd_addr(rd_addr), .rd_bal(rd_bal), .rd_pin(rd_pin), .rd_tries(rd_tries), .rd_lock(rd_lock),
        .wr_en(wr_en), .wr_addr(acc_q), .wr_bal(wr_bal), .wr_pin(wr_pin), .wr_tries(wr_tries),
        .wr_lock(wr_lock)
    );

    // Before a session exists the store is probed with the inserted card number.
    assign rd_addr   = (state_q == ST_IDLE) ? acc_num : acc_q;
    assign acc_bad   = 32'(acc_num) >= NUM_ACC;
    assign tmo_hit   = tmo_q == TCW'(TIMEOUT_CYC - 1);
    assign tries_inc = rd_tries + TW'(1);
    assign tries_hit = tries_inc == TW'(MAX_TRIES);
    assign wd_sum    = {1'b0, wd_q} + {1'b0, amt_q};
    assign dep_sum   = {1'b0, rd_bal} + {1'b0, amt_q};
    assign success_d = resp_valid_d ? (err_d == ERR_OK) : success_q;

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        tmo_d        = tmo_q;
        wd_d         = wd_q;
        op_d         = op_q;
        amt_d        = amt_q;
        npin_d       = npin_q;
        resp_valid_d = 1'b0;
        err_d        = err_q;
        balance_d    = balance_q;
        locked_d     = locked_q;
        wr_en        = 1'b0;
        wr_bal       = rd_bal;
        wr_pin       = rd_pin;
        wr_tries     = rd_tries;
        wr_lock      = rd_lock;
        case (state_q)
            ST_IDLE: begin
                if (card_valid) begin
                    if (acc_bad) begin
                        resp_valid_d = 1'b1;
                        err_d        = ERR_NO_ACC;
                    end else if (rd_lock) begin
                        resp_valid_d = 1'b1;
                        err_d        = ERR_LOCKED;
                        locked_d     = 1'b1;
                    end else begin
                        acc_d    = acc_num;
                        state_d  = ST_WAIT_PIN;
                        tmo_d    = '0;
                        wd_d     = '0;
                        locked_d = 1'b0;
                    end
                end
            end
            ST_WAIT_PIN: begin
                if (eject) begin
                    state_d = ST_IDLE;
                end else if (pin_valid) begin
                    resp_valid_d = 1'b1;
                    wr_en        = 1'b1;
                    tmo_d        = '0;
                    if (pin == rd_pin) begin
                        wr_tries  = '0;
                        state_d   = ST_MENU;
                        err_d     = ERR_OK;
                        balance_d = rd_bal;
                    end else if (tries_hit) begin
                        wr_tries = tries_inc;
                        wr_lock  = 1'b1;
                        state_d  = ST_IDLE;
                        err_d    = ERR_LOCKED;
                        locked_d = 1'b1;
                    end else begin
                        wr_tries = tries_inc;
                        err_d    = ERR_BAD_PIN;
                    end
                end else if (tmo_hit) begin
                    resp_valid_d = 1'b1;
                    err_d        = ERR_TIMEOUT;
                    state_d      = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + TCW'(1);
                end
            end
            ST_MENU: begin
                if (eject) begin
                    state_d = ST_IDLE;
                end else if (op_valid && op <= OP_EXIT) begin
                    tmo_d = '0;
                    if (op == OP_EXIT) begin
                        resp_valid_d = 1'b1;
                        err_d        = ERR_OK;
                        balance_d    = rd_bal;
                        state_d      = ST_IDLE;
                    end else begin
                        op_d    = op;
                        amt_d   = amount;
                        npin_d  = new_pin;
                        state_d = ST_EXEC;
                    end
                end else if (tmo_hit) begin
                    resp_valid_d = 1'b1;
                    err_d        = ERR_TIMEOUT;
                    state_d      = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + TCW'(1);
                end
            end
            ST_EXEC: begin
                resp_valid_d = 1'b1;
                err_d        = ERR_OK;
                balance_d    = rd_bal;
                tmo_d        = '0;
                state_d      = eject ? ST_IDLE : ST_MENU;
                case (op_q)
                    OP_WITHDRAW: begin
                        if (amt_q > rd_bal) begin
                            err_d = ERR_FUNDS;
                        end else if (wd_sum > (BAL_W + 1)'(WD_LIMIT)) begin
                            err_d = ERR_LIMIT;
                        end else begin
                            wr_en     = 1'b1;
                            wr_bal    = rd_bal - amt_q;
                            balance_d = rd_bal - amt_q;
                            wd_d      = wd_sum[BAL_W-1:0];
                        end
                    end
                    OP_DEPOSIT: begin
                        if (dep_sum[BAL_W]) begin
                            err_d = ERR_OVF;
                        end else begin
                            wr_en     = 1'b1;
                            wr_bal    = dep_sum[BAL_W-1:0];
                            balance_d = dep_sum[BAL_W-1:0];
                        end
                    end
                    OP_CHANGE_PIN: begin
                        if (npin_q == '0) begin
                            err_d = ERR_BAD_PIN;
                        end else begin
                            wr_en  = 1'b1;
                            wr_pin = npin_q;
                        end
                    end
                    default: ;
                endcase
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            acc_q        <= '0;
            tmo_q        <= '0;
            wd_q         <= '0;
            op_q         <= '0;
            amt_q        <= '0;
            npin_q       <= '0;
            resp_valid_q <= 1'b0;
            success_q    <= 1'b0;
            err_q        <= ERR_OK;
            balance_q    <= '0;
            locked_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            tmo_q        <= tmo_d;
            wd_q         <= wd_d;
            op_q         <= op_d;
            amt_q        <= amt_d;
            npin_q       <= npin_d;
            resp_valid_q <= resp_valid_d;
            success_q    <= success_d;
            err_q        <= err_d;
            balance_q    <= balance_d;
            locked_q     <= locked_d;
        end
    end

    assign state      = state_q;
    assign resp_valid = resp_valid_q;
    assign success    = success_q;
    assign err_code   = err_q;
    assign balance    = balance_q;
    assign locked     = locked_q;
endmodule

// File: tb/tb_atm_session_ctrl.sv
// tb_atm_session_ctrl: directed test-plan steps plus a randomized session walk,
// checked against an account-level reference model.
module tb_atm_session_ctrl;
    localparam int NA  = 10;
    localparam int TMO = 16;
    localparam int LIM = 500;
    localparam int MT  = 3;
    localparam int E_OK = 0, E_NOACC = 1, E_LOCKED = 2, E_BADPIN = 3;
    localparam int E_FUNDS = 4, E_LIMIT = 5, E_OVF = 6, E_TMO = 7;

    logic        clk = 0, rst = 0;
    logic        card_valid = 0, pin_valid = 0, op_valid = 0, eject = 0;
    logic [3:0]  acc_num = 0;
    logic [15:0] pin = 0, new_pin = 0;
    logic [2:0]  op = 0;
    logic [31:0] amount = 0;
    logic [2:0]  state, err_code;
    logic        resp_valid, success, locked;
    logic [31:0] balance;

    int     n_tests = 0, n_fail = 0;
    longint m_bal[NA];
    int     m_pin[NA];
    int     m_tries[NA];
    bit     m_lock[NA];
    int     m_st;
    int     m_acc;
    longint m_wd;

    always #5 clk = ~clk;

    atm_session_ctrl #(.NUM_ACC(NA)) dut (
        .clk(clk), .rst(rst), .card_valid(card_valid), .acc_num(acc_num),
        .pin_valid(pin_valid), .pin(pin), .op_valid(op_valid), .op(op), .amount(amount),
        .new_pin(new_pin), .eject(eject), .state(state), .resp_valid(resp_valid),
        .success(success), .err_code(err_code), .balance(balance), .locked(locked)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_resp(input string tag, input int e, input longint b, input int st);
        chk({tag, ".resp_valid"}, 64'(resp_valid), 1);
        chk({tag, ".err_code"}, 64'(err_code), 64'(e));
        chk({tag, ".success"}, 64'(success), 64'(e == E_OK));
        if (b >= 0) chk({tag, ".balance"}, 64'(balance), 64'(b));
        chk({tag, ".state"}, 64'(state), 64'(st));
    endtask

    task automatic reset_model();
        for (int i = 0; i < NA; i++) begin
            m_bal[i] = 1000; m_pin[i] = 1234; m_tries[i] = 0; m_lock[i] = 0;
        end
        m_st = 0; m_wd = 0; m_acc = 0;
    endtask

    task automatic do_card(input int a);
        card_valid = 1; acc_num = 4'(a);
        tick();
        card_valid = 0;
        if (a >= NA) chk_resp("no_acc", E_NOACC, -1, 0);
        else if (m_lock[a]) begin
            chk_resp("card_locked", E_LOCKED, -1, 0);
            chk("card_locked.locked", 64'(locked), 1);
        end else begin
            m_acc = a; m_wd = 0; m_st = 1;
            chk("card.resp_valid", 64'(resp_valid), 0);
            chk("card.state", 64'(state), 1);
            chk("card.locked", 64'(locked), 0);
        end
    endtask

    task automatic do_pin(input int p);
        pin_valid = 1; pin = 16'(p);
        tick();
        pin_valid = 0;
        if (p == m_pin[m_acc]) begin
            m_tries[m_acc] = 0; m_st = 2;
            chk_resp("pin_ok", E_OK, m_bal[m_acc], 2);
        end else begin
            m_tries[m_acc]++;
            if (m_tries[m_acc] >= MT) begin
                m_lock[m_acc] = 1; m_st = 0;
                chk_resp("pin_lock", E_LOCKED, -1, 0);
                chk("pin_lock.locked", 64'(locked), 1);
            end else chk_resp("pin_bad", E_BADPIN, -1, 1);
        end
    endtask

    function automatic int model_exec(input int o, input longint amt, input int np);
        case (o)
            1: begin
                if (amt > m_bal[m_acc]) return E_FUNDS;
                if (m_wd + amt > LIM) return E_LIMIT;
                m_bal[m_acc] -= amt; m_wd += amt;
                return E_OK;
            end
            2: begin
                if (m_bal[m_acc] + amt >= 64'h1_0000_0000) return E_OVF;
                m_bal[m_acc] += amt;
                return E_OK;
            end
            3: begin
                if (np == 0) return E_BADPIN;
                m_pin[m_acc] = np;
                return E_OK;
            end
            default: return E_OK;
        endcase
    endfunction

    task automatic do_op(input int o, input longint amt, input int np, input bit ej);
        int e;
        op_valid = 1; op = 3'(o); amount = 32'(amt); new_pin = 16'(np);
        tick();
        op_valid = 0;
        if (o == 4) begin
            m_st = 0;
            chk_resp("exit", E_OK, m_bal[m_acc], 0);
        end else if (o > 4) begin
            chk("undef_op.resp_valid", 64'(resp_valid), 0);
            chk("undef_op.state", 64'(state), 2);
        end else begin
            chk("op_accept.resp_valid", 64'(resp_valid), 0);
            chk("op_accept.state", 64'(state), 3);
            e = model_exec(o, amt, np);
            eject = ej;
            tick();
            eject = 0;
            m_st = ej ? 0 : 2;
            chk_resp($sformatf("op%0d", o), e, m_bal[m_acc], m_st);
        end
    endtask

    task automatic do_eject(input bit with_valid);
        eject = 1;
        pin_valid = with_valid && m_st == 1; pin = 16'(m_pin[m_acc]);
        op_valid = with_valid && m_st == 2; op = 3'd0;
        tick();
        eject = 0; pin_valid = 0; op_valid = 0;
        m_st = 0;
        chk("eject.resp_valid", 64'(resp_valid), 0);
        chk("eject.state", 64'(state), 0);
    endtask

    task automatic wait_timeout();
        for (int i = 1; i < TMO; i++) begin
            tick();
            chk("idle.resp_valid", 64'(resp_valid), 0);
        end
        tick();
        m_st = 0;
        chk_resp("timeout", E_TMO, -1, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int r, o;
        longint amt;
        reset_model();
        #12;
        chk("rst.state", 64'(state), 0);
        chk("rst.resp_valid", 64'(resp_valid), 0);
        chk("rst.success", 64'(success), 0);
        chk("rst.err_code", 64'(err_code), 0);
        chk("rst.balance", 64'(balance), 0);
        chk("rst.locked", 64'(locked), 0);
        rst = 1;

        do_card(3); do_pin(1234); do_op(0, 0, 0, 0); do_op(4, 0, 0, 0);
        do_card(3); do_pin(1234); do_op(1, 300, 0, 0); do_op(1, 250, 0, 0); do_op(4, 0, 0, 0);
        do_card(3); do_pin(1234); do_op(1, 250, 0, 0); do_op(1, 0, 0, 0); do_op(4, 0, 0, 0);
        do_card(4); do_pin(1234); do_op(1, 1200, 0, 0); do_op(2, 64'hFFFF_FE0C, 0, 0);
        do_op(2, 1000, 0, 0); do_op(4, 0, 0, 0);
        do_card(5); do_pin(1); do_pin(2); do_pin(3); do_card(5);
        do_card(6); do_pin(1234); do_op(3, 0, 4321, 0); do_op(3, 0, 0, 0); do_op(4, 0, 0, 0);
        do_card(6); do_pin(1234); do_pin(4321); do_op(6, 0, 0, 0); do_op(0, 0, 0, 0);
        wait_timeout();
        do_card(12);
        do_card(7); do_pin(1234); do_eject(1);
        do_card(7); do_pin(1234); do_op(1, 100, 0, 1);
        do_card(8); wait_timeout();
        do_card(8); do_eject(1);

        do_card(9); do_pin(1234);
        op_valid = 1; op = 3'd1; amount = 32'd100;
        tick();
        op_valid = 0;
        chk("rst_exec.state_pre", 64'(state), 3);
        #2 rst = 0;
        #1;
        chk("rst_exec.state", 64'(state), 0);
        chk("rst_exec.resp_valid", 64'(resp_valid), 0);
        chk("rst_exec.success", 64'(success), 0);
        chk("rst_exec.err_code", 64'(err_code), 0);
        chk("rst_exec.balance", 64'(balance), 0);
        chk("rst_exec.locked", 64'(locked), 0);
        reset_model();
        #2 rst = 1;
        do_card(5); do_pin(1234); do_op(4, 0, 0, 0);
        do_card(6); do_pin(1234); do_op(0, 0, 0, 0); do_op(4, 0, 0, 0);

        for (int it = 0; it < 400; it++) begin
            case (m_st)
                0: do_card($urandom_range(0, 11));
                1: begin
                    r = $urandom_range(0, 9);
                    if (r == 0) do_eject($urandom_range(0, 1) == 1);
                    else if (r < 8) do_pin(m_pin[m_acc]);
                    else do_pin($urandom_range(0, 65535));
                end
                default: begin
                    r = $urandom_range(0, 19);
                    if (r == 0) do_eject($urandom_range(0, 1) == 1);
                    else begin
                        o = $urandom_range(0, 4);
                        amt = (o == 2) ? ((r == 1) ? 64'hFFFF_FF00 : longint'($urandom_range(0, 2000)))
                                       : longint'($urandom_range(0, 400));
                        do_op(o, amt, (r == 2) ? 0 : $urandom_range(1, 9999), r == 3);
                    end
                end
            endcase
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
